clusterv_tile_sram_arbiter: RTL and testbench
=============================================

# clusterv_tile_sram_arbiter

Round-robin arbiter and sequencer that shares the tile SRAM's single read/write port (the sky130 OpenRAM 32x256 RW target) between N_REQ requesters, e.g. core fetch, core load/store and DMA. It accepts one valid/ready request per cycle and drives registered active-low SRAM controls. It returns a fixed-latency response to the requester that issued each access. It sits between the cluster core/DMA ports and the tile SRAM wrapper's t_ target port.

## Interface
- N_REQ, 2: number of requesters (2..4).
- ADDR_W, 8: word address width.
- DATA_W, 32: data width; byte-mask width is DATA_W/8.
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  request valid, one bit per requester.
- req_ready  out  N_REQ  request accepted this cycle (one-hot or zero).
- req_we  in  N_REQ  1 = write, 0 = read.
- req_wmask  in  N_REQ*DATA_W/8  byte enables, requester i at slice i.
- req_addr  in  N_REQ*ADDR_W  word address, requester i at slice i.
- req_wdata  in  N_REQ*DATA_W  write data, requester i at slice i.
- rsp_valid  out  N_REQ  response strobe, one cycle, no backpressure.
- rsp_rdata  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid.
- t_csb  out  1  SRAM chip select, active low.
- t_web  out  1  SRAM write enable, active low.
- t_wmask  out  DATA_W/8  SRAM byte mask.
- t_addr  out  ADDR_W  SRAM address.
- t_dat_w  out  DATA_W  SRAM write data.
- t_dat_r  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read.

## Operation
- Arbitration (combinational):
  - Search begins at rr_ptr and proceeds rr_ptr, rr_ptr+1, … mod N_REQ.
  - The first requester with req_valid set gets req_ready=1. At most one ready bit is set per cycle.
  - A request is accepted when req_valid[i] and req_ready[i] are both high.
- Pointer update: on accept of requester g, rr_ptr <= (g+1) mod N_REQ. With no accept, rr_ptr holds.
- Command stage (registered): on accept, the following are loaded from the granted slice:
  - t_csb <= 0
  - t_web <= ~req_we
  - t_wmask <= wmask for writes, all-zero for reads
  - t_addr, t_dat_w <= the granted requester's values
- Idle command: with no accept, t_csb <= 1 and t_web <= 1. t_addr, t_wmask and t_dat_w hold their previous values.
- Tag pipeline: the granted index and we bit are carried two stages alongside the command.
- Response stage:
  - rsp_valid[tag] pulses for 1 cycle for every accepted access, reads and writes alike.
  - rsp_rdata = t_dat_r for reads; it is forced to 0 on write acks and when no response is pending.
- Ordering: accesses reach the SRAM in accept order. A read accepted after a write to the same address returns the new data, including back-to-back accepts.
- No internal storage beyond the pipeline. Full throughput is 1 access per cycle, continuous.
- Reset (including mid-operation):
  - rr_ptr=0, t_csb=1, t_web=1, t_wmask=0, t_addr=0, t_dat_w=0, tag pipeline valids=0.
  - Outputs: rsp_valid=0, rsp_rdata=0, req_ready=0 while reset is high.
  - In-flight accesses are dropped with no response. A write already presented with t_csb=0 may still complete in the SRAM.

## Timing
- Cycle A: request accepted (valid & ready).
- Cycle A+1: t_csb=0 with command; the SRAM samples at the end of A+1.
- Cycle A+2: t_dat_r valid; rsp_valid[g]=1, rsp_rdata=t_dat_r.
- Fixed latency of 2 cycles from accept to response, for both reads and writes.
- req_ready depends combinationally on req_valid and rr_ptr only, never on req_we, req_wmask, req_addr or req_wdata.
- The first accept is possible in the cycle after reset deasserts.

## Test plan
- Single read, N_REQ=2:
  - Stimulus: preload addr 0x10 = 0xDEADBEEF; requester 1 reads 0x10.
  - Response: ready[1] in cycle A; t_csb=0, t_web=1, t_addr=0x10 in A+1; rsp_valid=2'b10 with rdata 0xDEADBEEF in A+2.
- Masked write then read:
  - Stimulus: requester 0 writes 0x11223344 with wmask 4'b0101 to addr 0x05 (old value 0xAAAAAAAA); back-to-back read of 0x05.
  - Response: write ack rdata=0; read returns 0xAA22AA44.
- Round-robin fairness:
  - Stimulus: both requesters hold valid for 6 cycles.
  - Response: grants alternate 0,1,0,1,0,1; each gets 3 responses in order.
- Single requester streaming:
  - Stimulus: requester 1 alone issues 8 reads at consecutive addresses.
  - Response: ready every cycle, 8 consecutive rsp_valid[1] pulses, t_csb low for 8 consecutive cycles.
- Reset mid-stream:
  - Stimulus: assert reset the cycle after accept of a read.
  - Response: no rsp_valid; t_csb=1, rr_ptr=0; the first post-reset grant with both requesters valid goes to requester 0.
- Idle:
  - Stimulus: no valids for 10 cycles.
  - Response: t_csb=1, t_web=1, rsp_valid=0, rsp_rdata=0 throughout.

Source files
------------

// File: rtl/clusterv_tile_sram_arbiter_if.sv
// Requester-side and SRAM-side signals of the tile SRAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM macro.
interface clusterv_tile_sram_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ-1:0]              req_we;
  logic [N_REQ-1:0][MASK_W-1:0]  req_wmask;
  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr;
  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata;
  logic [N_REQ-1:0]              rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;

  logic                          t_csb;
  logic                          t_web;
  logic [MASK_W-1:0]             t_wmask;
  logic [ADDR_W-1:0]             t_addr;
  logic [DATA_W-1:0]             t_dat_w;
  logic [DATA_W-1:0]             t_dat_r;

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata, t_dat_r,
    input  req_ready, rsp_valid, rsp_rdata, t_csb, t_web, t_wmask, t_addr, t_dat_w
  );

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata, t_dat_r,
    output req_ready, rsp_valid, rsp_rdata, t_csb, t_web, t_wmask, t_addr, t_dat_w
  );
endinterface

// File: rtl/clusterv_tile_sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between N_REQ requesters.
// Accept -> registered active-low command -> response two cycles after accept; no backpressure on responses.
module clusterv_tile_sram_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  clusterv_tile_sram_arbiter_if.slave   bus_io
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W  = PTR_W + 1;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              t_csb_q, t_csb_d;
  logic              t_web_q, t_web_d;
  logic [MASK_W-1:0] t_wmask_q, t_wmask_d;
  logic [ADDR_W-1:0] t_addr_q, t_addr_d;
  logic [DATA_W-1:0] t_dat_w_q, t_dat_w_d;
  logic              s1_vld_q, s1_vld_d;
  logic [PTR_W-1:0]  s1_idx_q, s1_idx_d;
  logic              s1_we_q, s1_we_d;
  logic              s2_vld_q, s2_vld_d;
  logic [PTR_W-1:0]  s2_idx_q, s2_idx_d;
  logic              s2_we_q, s2_we_d;

  logic              grant_vld;
  logic [PTR_W-1:0]  grant_idx;
  logic [SUM_W-1:0]  cand_sum;
  logic [PTR_W-1:0]  cand;

  // Search from rr_ptr upward with wraparound; ready never looks at payload fields.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (cand_sum >= SUM_W'(N_REQ)) begin
        cand_sum = cand_sum - SUM_W'(N_REQ);
      end
      cand = cand_sum[PTR_W-1:0];
      if (!grant_vld && !rst_i && bus_io.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    bus_io.req_ready = '0;
    if (grant_vld) begin
      bus_io.req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    t_csb_d   = 1'b1;
    t_web_d   = 1'b1;
    t_wmask_d = t_wmask_q;
    t_addr_d  = t_addr_q;
    t_dat_w_d = t_dat_w_q;
    s1_vld_d  = grant_vld;
    s1_idx_d  = grant_idx;
    s1_we_d   = 1'b0;
    s2_vld_d  = s1_vld_q;
    s2_idx_d  = s1_idx_q;
    s2_we_d   = s1_we_q;
    if (grant_vld) begin
      rr_ptr_d  = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      t_csb_d   = 1'b0;
      t_web_d   = ~bus_io.req_we[grant_idx];
      // Reads present an all-zero mask so the macro never sees stray byte enables.
      t_wmask_d = bus_io.req_we[grant_idx] ? bus_io.req_wmask[grant_idx] : '0;
      t_addr_d  = bus_io.req_addr[grant_idx];
      t_dat_w_d = bus_io.req_wdata[grant_idx];
      s1_we_d   = bus_io.req_we[grant_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      t_csb_q   <= 1'b1;
      t_web_q   <= 1'b1;
      t_wmask_q <= '0;
      t_addr_q  <= '0;
      t_dat_w_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_idx_q  <= '0;
      s1_we_q   <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_idx_q  <= '0;
      s2_we_q   <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      t_csb_q   <= t_csb_d;
      t_web_q   <= t_web_d;
      t_wmask_q <= t_wmask_d;
      t_addr_q  <= t_addr_d;
      t_dat_w_q <= t_dat_w_d;
      s1_vld_q  <= s1_vld_d;
      s1_idx_q  <= s1_idx_d;
      s1_we_q   <= s1_we_d;
      s2_vld_q  <= s2_vld_d;
      s2_idx_q  <= s2_idx_d;
      s2_we_q   <= s2_we_d;
    end
  end

  assign bus_io.t_csb   = t_csb_q;
  assign bus_io.t_web   = t_web_q;
  assign bus_io.t_wmask = t_wmask_q;
  assign bus_io.t_addr  = t_addr_q;
  assign bus_io.t_dat_w = t_dat_w_q;

  // Responses are masked while reset is held so an in-flight access never reports.
  always_comb begin
    bus_io.rsp_valid = '0;
    if (s2_vld_q && !rst_i) begin
      bus_io.rsp_valid[s2_idx_q] = 1'b1;
    end
  end

  assign bus_io.rsp_rdata = (s2_vld_q && !s2_we_q && !rst_i) ? bus_io.t_dat_r : '0;
endmodule

// File: tb/tb_clusterv_tile_sram_arbiter.sv
// Bench for the tile SRAM arbiter: behavioural SRAM plus an in-order reference model of accesses.
module tb_clusterv_tile_sram_arbiter;
  localparam int N = 2;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clusterv_tile_sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  clusterv_tile_sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus.slave)
  );

  // Behavioural OpenRAM-style macro: sampled on the rising edge, read data next cycle.
  logic [DW-1:0] sram_mem [256];
  logic [DW-1:0] sram_dout;
  always @(posedge clk) begin
    if (!bus.t_csb) begin
      if (!bus.t_web) begin
        for (int b = 0; b < DW / 8; b++)
          if (bus.t_wmask[b]) sram_mem[bus.t_addr][8*b +: 8] <= bus.t_dat_w[8*b +: 8];
        sram_dout <= $urandom;
      end else begin
        sram_dout <= sram_mem[bus.t_addr];
      end
    end
  end
  assign bus.t_dat_r = sram_dout;

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] ref_mem [256];
  int            m_ptr = 0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  bit            cmd_known = 1'b0;
  logic          e_csb, e_web;
  logic [3:0]    e_mask;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [3:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_we[i]    = we;
    bus.req_wmask[i] = m;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = d;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 4'h0, '0, '0);
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step();
    int            g;
    logic [N-1:0]  er, ev;
    logic [DW-1:0] ed;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0]    m;
    #1;
    g = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        automatic int i = (m_ptr + k) % N;
        if (g < 0 && bus.req_valid[i]) g = i;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ev = '0;
    ed = '0;
    if (!rst && q.size() > 0 && q[0].due == cyc) begin
      ev[q[0].idx] = 1'b1;
      ed = q[0].data;
    end
    chk("req_ready", DW'(bus.req_ready), DW'(er));
    chk("rsp_valid", DW'(bus.rsp_valid), DW'(ev));
    chk("rsp_rdata", bus.rsp_rdata, ed);
    if (cmd_known) begin
      chk("t_csb", DW'(bus.t_csb), DW'(e_csb));
      chk("t_web", DW'(bus.t_web), DW'(e_web));
      chk("t_wmask", DW'(bus.t_wmask), DW'(e_mask));
      chk("t_addr", DW'(bus.t_addr), DW'(e_addr));
      chk("t_dat_w", bus.t_dat_w, e_wd);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ptr = 0;
      e_csb = 1'b1; e_web = 1'b1; e_mask = '0; e_addr = '0; e_wd = '0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (g >= 0) begin
        we = bus.req_we[g];
        a  = bus.req_addr[g];
        wd = bus.req_wdata[g];
        m  = bus.req_wmask[g];
        if (we) begin
          for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
          q.push_back('{due: cyc + 2, idx: g, data: '0});
        end else begin
          q.push_back('{due: cyc + 2, idx: g, data: ref_mem[a]});
        end
        m_ptr = (g + 1) % N;
        e_csb = 1'b0; e_web = ~we; e_mask = we ? m : 4'h0; e_addr = a; e_wd = wd;
      end else begin
        e_csb = 1'b1; e_web = 1'b1;
      end
    end
    cmd_known = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Fill addresses 0..31 through the arbiter so model and macro agree.
    for (int a = 0; a < 32; a++) begin
      set_req(0, 1'b1, 1'b1, 4'hF, AW'(a), $urandom);
      step();
    end
    idle_inputs();
    step();
    step();

    // Single read of a preloaded word by requester 1.
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF);
    step();
    idle_inputs();
    step();
    set_req(1, 1'b1, 1'b0, 4'h0, 8'h10, '0);
    step();
    idle_inputs();
    step();
    chk("single_read_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    step();

    // Masked write followed back-to-back by a read of the same word.
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h05, 32'hAAAAAAAA);
    step();
    idle_inputs();
    step();
    step();
    set_req(0, 1'b1, 1'b1, 4'b0101, 8'h05, 32'h11223344);
    step();
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h05, 32'h55555555);
    step();
    idle_inputs();
    step();
    chk("masked_read_rdata", bus.rsp_rdata, 32'hAA22AA44);
    step();

    // Both requesters contend for six cycles.
    for (int c = 0; c < 6; c++) begin
      set_req(0, 1'b1, 1'b0, 4'h0, AW'($urandom_range(0, 31)), '0);
      set_req(1, 1'b1, 1'b0, 4'h0, AW'($urandom_range(0, 31)), '0);
      step();
    end
    idle_inputs();
    step();
    step();

    // Requester 1 streams eight consecutive reads.
    for (int c = 0; c < 8; c++) begin
      set_req(1, 1'b1, 1'b0, 4'h0, AW'(c), '0);
      step();
    end
    idle_inputs();
    step();
    step();

    // Reset arrives the cycle after a read is accepted.
    set_req(1, 1'b1, 1'b0, 4'h0, 8'h03, '0);
    step();
    rst = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'h0, 8'h04, '0);
    step();
    rst = 1'b0;
    step();
    idle_inputs();
    step();
    step();
    step();

    // Quiet period.
    for (int c = 0; c < 10; c++) step();

    // Random traffic over a small address window to provoke read-after-write hazards.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom), 1'($urandom), 4'($urandom), AW'($urandom_range(0, 31)), $urandom);
      step();
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
